des_core_sched: RTL

//  Shares one iterative 16-round DES core between two block requesters (ch0, ch1).

---
 rtl/des_ch_if.sv | 23 ++
 rtl/des_core_sched.sv | 123 ++++++++++++
 2 files changed

// File: rtl/des_ch_if.sv
// Requester channel bundle for the shared DES core scheduler.
// Master is the PipeIn/PipeOut front end; slave is the scheduler.
interface des_ch_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_decrypt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_core_sched.sv
// Round-robin scheduler sharing one iterative 16-round DES core by two channels.
// Optional DES_BLOCK_CNT_EN adds per-channel completed-block counters.
module des_core_sched #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk1,
  input  logic              reset_n,
  des_ch_if.slave           ch0,
  des_ch_if.slave           ch1,
  output logic [3:0]        core_round,
  output logic [DATA_W-1:0] core_in,
  output logic              core_decrypt,
  input  logic [DATA_W-1:0] core_out,
  output logic              busy
`ifdef DES_BLOCK_CNT_EN
  ,
  output logic [CNT_W-1:0]  ch0_blk_cnt,
  output logic [CNT_W-1:0]  ch1_blk_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_t;

  state_t            state;
  logic              owner;
  logic              rr;
  logic              v0, v1;
  logic [DATA_W-1:0] d0, d1;
  logic              elig0, elig1;
  logic              gnt0, gnt1;

  assign elig0 = ch0.in_valid && !v0;
  assign elig1 = ch1.in_valid && !v1;

  // rr names the channel preferred on a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        (elig0 && elig1):  begin
          gnt0 = !rr;
          gnt1 = rr;
        end
        (elig0 && !elig1): gnt0 = 1'b1;
        (!elig0 && elig1): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign ch0.in_ready  = gnt0;
  assign ch1.in_ready  = gnt1;
  assign ch0.out_valid = v0;
  assign ch1.out_valid = v1;
  assign ch0.out_data  = d0;
  assign ch1.out_data  = d1;

  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      core_round   <= 4'd0;
      core_in      <= '0;
      core_decrypt <= 1'b0;
      owner        <= 1'b0;
      rr           <= 1'b0;
      v0           <= 1'b0;
      v1           <= 1'b0;
      d0           <= '0;
      d1           <= '0;
`ifdef DES_BLOCK_CNT_EN
      ch0_blk_cnt  <= '0;
      ch1_blk_cnt  <= '0;
`endif
    end else begin
      if (v0 && ch0.out_ready) v0 <= 1'b0;
      if (v1 && ch1.out_ready) v1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            core_in      <= gnt1 ? ch1.in_data : ch0.in_data;
            core_decrypt <= gnt1 ? ch1.in_decrypt
                                 : ch0.in_decrypt;
            owner        <= gnt1;
            rr           <= gnt0;
            core_round   <= 4'd0;
            state        <= ROUND;
            busy         <= 1'b1;
          end
        end
        ROUND: begin
          if (core_round == 4'd15) begin
            if (owner) begin
              v1 <= 1'b1;
              d1 <= core_out;
`ifdef DES_BLOCK_CNT_EN
              ch1_blk_cnt <= ch1_blk_cnt + 1'b1;
`endif
            end else begin
              v0 <= 1'b1;
              d0 <= core_out;
`ifdef DES_BLOCK_CNT_EN
              ch0_blk_cnt <= ch0_blk_cnt + 1'b1;
`endif
            end
            core_round <= 4'd0;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            core_round <= core_round + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
